sw_result_collector: RTL

Sink for the SmithWaterman result stream: valid_o, result_o, change_q_o, match_idx_o and max_result_o.
- Tracks the target index and query index of each beat.
- Independently recomputes the per-query best score and its argmax, and checks them against the core's reported match_idx/max_result.
- Packs one record per finished query into a small first-word-fall-through (FWFT) FIFO, read by the host over a valid/ready port.
- Sits between the core and the host/readout logic, replacing bench-side bookkeeping in silicon.

---
 rtl/sw_result_collector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/sw_result_collector.sv
// Purpose: sink for the SmithWaterman result stream. Tracks target/query
// indices, recomputes per-query max/argmax, checks them against the core's
// report and queues one record per finished query in a small FWFT FIFO.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   clear_i              synchronous soft clear (same effect as rst)
//   valid_i, result_i    result beat and its score
//   change_q_i           qualifies valid_i: last target of the current query
//   match_idx_i          core-reported argmax (sampled on a last beat)
//   max_result_i         core-reported max (sampled on a last beat)
//   rec_valid_o, rec_ready_i      host record handshake
//   rec_q_idx_o, rec_match_idx_o  record query number and argmax
//   rec_max_o, rec_t_count_o      record max and target count
//   rec_ok_o             core report matched the internal values
//   t_idx_o, q_idx_o     index of the next beat, current query number
//   err_o, overflow_o    sticky mismatch / dropped-record flags
module sw_result_collector #(
  parameter int unsigned CALC_BIT   = 16,
  parameter int unsigned T_IDX_BIT  = 10,
  parameter int unsigned Q_IDX_BIT  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 valid_i,
  input  logic [CALC_BIT-1:0]  result_i,
  input  logic                 change_q_i,
  input  logic [T_IDX_BIT-1:0] match_idx_i,
  input  logic [CALC_BIT-1:0]  max_result_i,
  output logic                 rec_valid_o,
  input  logic                 rec_ready_i,
  output logic [Q_IDX_BIT-1:0] rec_q_idx_o,
  output logic [T_IDX_BIT-1:0] rec_match_idx_o,
  output logic [CALC_BIT-1:0]  rec_max_o,
  output logic [T_IDX_BIT:0]   rec_t_count_o,
  output logic                 rec_ok_o,
  output logic [T_IDX_BIT-1:0] t_idx_o,
  output logic [Q_IDX_BIT-1:0] q_idx_o,
  output logic                 err_o,
  output logic                 overflow_o
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TC_W  = T_IDX_BIT + 1;

  typedef struct packed {
    logic [Q_IDX_BIT-1:0] q_idx;
    logic [T_IDX_BIT-1:0] arg;
    logic [CALC_BIT-1:0]  max;
    logic [TC_W-1:0]      t_count;
    logic                 ok;
  } rec_t;

  logic [T_IDX_BIT-1:0] t_idx;
  logic [TC_W-1:0]      t_count;
  logic [Q_IDX_BIT-1:0] q_idx;
  logic [CALC_BIT-1:0]  run_max;
  logic [T_IDX_BIT-1:0] run_arg;
  logic                 err;
  logic                 overflow;
  rec_t                 mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  // Beat-level combinational view: max/arg including the current beat.
  logic                 first_c;
  logic                 beat_c;
  logic                 last_c;
  logic [CALC_BIT-1:0]  new_max_c;
  logic [T_IDX_BIT-1:0] new_arg_c;
  logic [TC_W-1:0]      new_count_c;
  logic                 ok_c;
  logic                 full_c;
  logic                 pop_c;
  logic                 push_c;
  rec_t                 new_rec_c;

  always_comb begin
    first_c     = (t_idx == '0);
    beat_c      = valid_i;
    last_c      = valid_i & change_q_i;
    new_max_c   = run_max;
    new_arg_c   = run_arg;
    if (first_c) begin
      new_max_c = result_i;
      new_arg_c = '0;
    end else if (result_i > run_max) begin
      // Strict compare: earliest target keeps a tie.
      new_max_c = result_i;
      new_arg_c = t_idx;
    end
    new_count_c = (&t_count) ? t_count : t_count + TC_W'(1);
    ok_c        = (new_max_c == max_result_i) && (new_arg_c == match_idx_i);
    full_c      = (count == CNT_W'(FIFO_DEPTH));
    pop_c       = (count != '0) & rec_ready_i;
    // A same-cycle pop frees the slot a full FIFO needs.
    push_c      = last_c & (~full_c | pop_c);
    new_rec_c   = '{q_idx: q_idx, arg: new_arg_c, max: new_max_c,
                    t_count: new_count_c, ok: ok_c};
  end

  // Beat tracking, record FIFO and sticky flags.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      t_idx    <= '0;
      t_count  <= '0;
      q_idx    <= '0;
      run_max  <= '0;
      run_arg  <= '0;
      err      <= 1'b0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (beat_c) begin
        run_max <= new_max_c;
        run_arg <= new_arg_c;
        if (last_c) begin
          t_idx   <= '0;
          t_count <= '0;
          q_idx   <= q_idx + Q_IDX_BIT'(1);
          if (!ok_c) err <= 1'b1;
          if (!push_c) overflow <= 1'b1;
        end else begin
          t_idx   <= t_idx + T_IDX_BIT'(1);
          t_count <= new_count_c;
        end
      end
      if (push_c) begin
        mem[wr_ptr] <= new_rec_c;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)      count <= count + CNT_W'(1);
      else if (!push_c && pop_c) count <= count - CNT_W'(1);
    end
  end

  // FWFT head: the record at rd_ptr is presented directly.
  rec_t head;
  assign head            = mem[rd_ptr];
  assign rec_valid_o     = (count != '0);
  assign rec_q_idx_o     = head.q_idx;
  assign rec_match_idx_o = head.arg;
  assign rec_max_o       = head.max;
  assign rec_t_count_o   = head.t_count;
  assign rec_ok_o        = head.ok;
  assign t_idx_o         = t_idx;
  assign q_idx_o         = q_idx;
  assign err_o           = err;
  assign overflow_o      = overflow;

endmodule
